// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ message reporters.
// Each packet is a header {4'hA, id} followed by the latched message, MSB byte first.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MSG_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*MSG_BYTES*8-1:0] msg,
  output logic [NUM_REQ-1:0]             ack,
  output logic [7:0]                     tx_byte,
  output logic                           tx_start,
  input  logic                           tx_busy,
  output logic [3:0]                     grant_id,
  output logic                           active
);
  localparam int MW = MSG_BYTES * 8;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_next;
  logic [3:0]         last, last_next;
  logic [3:0]         cnt, cnt_next;
  logic [MW-1:0]      shift, shift_next;
  logic [NUM_REQ-1:0] ack_next;
  logic [7:0]         tx_byte_next;
  logic               tx_start_next;
  logic [3:0]         grant_id_next;
  logic               found;
  int                 win;
  int                 idx;

  // First requester above the previous winner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && ((req >> idx) & NUM_REQ'(1)) != '0) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_next    = state;
    last_next     = last;
    cnt_next      = cnt;
    shift_next    = shift;
    ack_next      = '0;
    tx_start_next = 1'b0;
    tx_byte_next  = tx_byte;
    grant_id_next = grant_id;
    case (state)
      IDLE: begin
        // A busy UART (e.g. reset landed mid-byte) holds off the grant.
        if (found && !tx_busy) begin
          shift_next    = MW'(msg >> (win * MW));
          ack_next      = NUM_REQ'(1) << win;
          grant_id_next = 4'(win);
          tx_byte_next  = {4'hA, 4'(win)};
          tx_start_next = 1'b1;
          cnt_next      = 4'(MSG_BYTES);
          state_next    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (cnt != 4'd0) begin
            tx_byte_next  = shift[MW-1 -: 8];
            shift_next    = shift << 8;
            tx_start_next = 1'b1;
            cnt_next      = cnt - 4'd1;
            state_next    = WAIT_BUSY;
          end else begin
            last_next  = grant_id;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 4'(NUM_REQ - 1);
      cnt      <= 4'd0;
      shift    <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_byte  <= 8'd0;
      grant_id <= 4'd0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      cnt      <= cnt_next;
      shift    <= shift_next;
      ack      <= ack_next;
      tx_start <= tx_start_next;
      tx_byte  <= tx_byte_next;
      grant_id <= grant_id_next;
    end
  end

  assign active = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single `uart_tx` transmitter among `NUM_REQ` requesters, typically the per-core result/nonce reporters. Requesters present fixed-length messages; the block grants round-robin, latches the winning message, and sends it to the UART as one packet. Each packet is a header byte carrying the requester ID followed by the message bytes, MSB first. It sits between the reporting logic and the `tx_byte`/`start`/`busy` port of `uart_tx`, on the same clock.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 1..16.
- `MSG_BYTES`, 4: payload bytes per message; legal range 1..15.

- `clk`  in  1  communications clock, the same clock as `uart_tx`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level; held until the matching `ack`.
- `msg`  in  NUM_REQ*MSG_BYTES*8  payloads; requester i occupies bits [(i+1)*MSG_BYTES*8-1 : i*MSG_BYTES*8].
- `ack`  out  NUM_REQ  one-cycle pulse: message latched, requester may drop `req` or change `msg`.
- `tx_byte`  out  8  byte to the UART; registered.
- `tx_start`  out  1  one-cycle start pulse to the UART; registered.
- `tx_busy`  in  1  UART busy flag.
- `grant_id`  out  4  ID of the requester being transmitted; valid while `active`.
- `active`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- Packet format: header `{4'hA, id[3:0]}`, then bytes MSG_BYTES-1 down to 0 of the latched message. Total MSG_BYTES+1 bytes.
- **IDLE**: grants when any `req` bit is high and `tx_busy`=0. A high `tx_busy` blocks the grant; this covers a reset that lands mid-byte.
- **Grant edge**: all of the following happen on the same clock edge.
  - Winner = first set `req` bit searching upward from `last+1`, with wrap-around.
  - The winner's message is latched into the shift buffer.
  - `ack[winner]`<=1, `grant_id`<=winner, `tx_byte`<=header, `tx_start`<=1.
  - Byte counter <= MSG_BYTES; state -> WAIT_BUSY.
- `tx_start` and `ack` are always cleared on the following edge.
- **WAIT_BUSY**: on `tx_busy`=1 -> WAIT_DONE.
- **WAIT_DONE**: on `tx_busy`=0:
  - If counter != 0: `tx_byte`<=next buffer byte (MSB first), `tx_start`<=1, counter decrements, -> WAIT_BUSY.
  - If counter = 0: `last`<=`grant_id`, -> IDLE.
- Round-robin pointer `last` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- `req` bits of non-granted requesters are ignored during a packet. `msg` changes after `ack` have no effect on the packet in flight.
- A `req` that drops before its `ack` withdraws the request; no partial state is kept.
- `req` still high on the cycle after `ack` is treated as a new request, queued by round-robin. Requesters drop `req` on `ack`.
- **Reset (async assert)**: state=IDLE, `ack`=0, `tx_start`=0, `tx_byte`=0, `grant_id`=0, `active`=0, `last`=NUM_REQ-1, buffer and counter=0. A packet interrupted by reset is abandoned and never resumed.

## Timing
- Request-to-grant latency: `req` high in IDLE with `tx_busy`=0 at edge n → `ack`, `tx_start` and header on `tx_byte` valid in cycle n+1.
- `tx_start` is exactly 1 cycle wide. `tx_byte` is held stable from `tx_start` until the next `tx_start`.
- UART `busy` rises 1 cycle after `start`. The arbiter never issues `tx_start` while `tx_busy`=1, nor before it has seen `tx_busy` go high for the previous byte.
- Inter-byte gap: the next `tx_start` is 1 cycle after `tx_busy` falls.
- Inter-packet gap: `active` falls 1 cycle after the last `tx_busy` fall. The next grant comes at the earliest on the following edge.
- With all requesters continuously requesting, grants cycle 0,1,…,NUM_REQ-1,0,… with no requester skipped.

## Test plan
- **Single request**: `req`=4'b0100, msg2=32'hDEADBEEF.
  - Expect: `ack`=4'b0100 for 1 cycle; bytes A2, DE, AD, BE, EF, in order.
  - Expect: exactly 5 `tx_start` pulses; `active` low after the last byte.
- **All four requesting from reset**:
  - Expect: packet headers A0, A1, A2, A3, in that order.
  - Expect: each `ack` fires once, at its own grant.
- **Fairness**: requester 1 re-requests immediately after every ack while requester 3 requests once.
  - Expect: requester 3 is granted directly after the current requester-1 packet; no second requester-1 grant occurs first.
- **Message stability**: change msg0 to 32'h00000000 the cycle after `ack[0]`.
  - Expect: the original msg0 value is transmitted in full.
- **Reset mid-packet**: assert `rst_n`=0 while byte 2 is in flight, with the UART model still busy.
  - Expect: all outputs return to reset values.
  - Expect: a pending `req` is not granted until `tx_busy`=0; the new packet starts with its header.
- **Withdrawn request**: pulse `req[1]` for 1 cycle while another packet is active.
  - Expect: no `ack[1]` and no header A1 ever transmitted.
